// File: rtl/dec_pkg.sv
// Shared constants and state encoding for the decoder scan sequencer.
package dec_pkg;
    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    typedef enum logic [1:0] {IDLE, DWELL, GAP} scan_state_t;
endpackage

// File: rtl/ch_find_next.sv
// Combinational next-channel search: next set bit above cur, circling to the lowest.
module ch_find_next
    import dec_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  cur,
    input  logic              from_start,
    output logic [SEL_W-1:0]  nxt,
    output logic              wrap
);
    logic [SEL_W-1:0] lo;
    logic [SEL_W-1:0] hi;
    logic             lo_found;
    logic             hi_found;

    always_comb begin
        lo       = '0;
        hi       = '0;
        lo_found = 1'b0;
        hi_found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (mask[i] && !lo_found) begin
                lo       = SEL_W'(i);
                lo_found = 1'b1;
            end
            if (mask[i] && !hi_found && (SEL_W'(i) > cur)) begin
                hi       = SEL_W'(i);
                hi_found = 1'b1;
            end
        end
        // With no higher bit the search circles back to the lowest set bit.
        nxt  = (from_start || !hi_found) ? lo : hi;
        wrap = !from_start && !hi_found;
    end
endmodule

// File: rtl/dec_scan_ctrl.sv
// Scan sequencer driving a 3-to-8 decoder: dwell per masked channel, one-cycle gap between.
module dec_scan_ctrl
    import dec_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               cont,
    input  logic [NUM_CH-1:0]  mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic               en,
    output logic [SEL_W-1:0]   a,
    output logic               busy,
    output logic               sweep_done
);
    scan_state_t        state;
    logic [DWELL_W-1:0] cnt;
    logic [NUM_CH-1:0]  mask_sh;
    logic [DWELL_W-1:0] dwell_sh;
    logic               cont_sh;

    logic [DWELL_W-1:0] dwell_eff;
    logic [SEL_W-1:0]   nxt;
    logic               wrap;
    logic               idle;

    assign idle      = (state == IDLE);
    assign dwell_eff = (dwell_sh == '0) ? DWELL_W'(1) : dwell_sh;

    // In IDLE the live mask gives the first channel; afterwards the shadow copy is searched.
    ch_find_next u_find (
        .mask       (idle ? mask : mask_sh),
        .cur        (a),
        .from_start (idle),
        .nxt        (nxt),
        .wrap       (wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            en         <= 1'b0;
            a          <= '0;
            busy       <= 1'b0;
            sweep_done <= 1'b0;
            cnt        <= '0;
            mask_sh    <= '0;
            dwell_sh   <= '0;
            cont_sh    <= 1'b0;
        end else begin
            sweep_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !stop && (mask != '0)) begin
                        mask_sh  <= mask;
                        dwell_sh <= dwell;
                        cont_sh  <= cont;
                        a        <= nxt;
                        en       <= 1'b1;
                        busy     <= 1'b1;
                        cnt      <= DWELL_W'(1);
                        state    <= DWELL;
                    end
                end
                DWELL: begin
                    if (stop) begin
                        en    <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt == dwell_eff) begin
                        // Select only moves here, while en is dropping.
                        en         <= 1'b0;
                        a          <= (wrap && !cont_sh) ? a : nxt;
                        sweep_done <= wrap;
                        state      <= GAP;
                    end else begin
                        cnt <= cnt + DWELL_W'(1);
                    end
                end
                GAP: begin
                    // sweep_done doubles as the "this gap ended a sweep" flag.
                    if (stop || (sweep_done && !cont_sh)) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        en    <= 1'b1;
                        cnt   <= DWELL_W'(1);
                        state <= DWELL;
                    end
                end
                default: begin
                    en    <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dec_scan_ctrl.sv
// Bench for dec_scan_ctrl: sweep-level trace model checked every cycle plus directed literals.
module tb_dec_scan_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       cont = 1'b0;
    logic [7:0] mask = '0;
    logic [7:0] dwell = '0;
    logic       en;
    logic [2:0] a;
    logic       busy;
    logic       sweep_done;

    int checks = 0;
    int errors = 0;

    dec_scan_ctrl #(.DWELL_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .cont       (cont),
        .mask       (mask),
        .dwell      (dwell),
        .en         (en),
        .a          (a),
        .busy       (busy),
        .sweep_done (sweep_done)
    );

    always #5 clk = ~clk;

    // Model: a sweep is expanded into its full per-cycle output trace up front.
    typedef struct packed {
        logic       en;
        logic [2:0] a;
        logic       busy;
        logic       sd;
    } obs_t;

    obs_t m = '0;
    obs_t q[$];
    logic [7:0] m_mask = '0;
    logic [7:0] m_dwell = '0;
    logic       m_cont = 1'b0;

    task automatic gen_sweep(input logic [7:0] msk, input logic [7:0] dw, input logic cn);
        int ch[$];
        int d;
        obs_t e;
        d = (dw == 0) ? 1 : int'(dw);
        for (int i = 0; i < 8; i++) if (msk[i]) ch.push_back(i);
        for (int k = 0; k < ch.size(); k++) begin
            for (int j = 0; j < d; j++) begin
                e = '{en: 1'b1, a: 3'(ch[k]), busy: 1'b1, sd: 1'b0};
                q.push_back(e);
            end
            if (k < ch.size() - 1) e = '{en: 1'b0, a: 3'(ch[k+1]), busy: 1'b1, sd: 1'b0};
            else e = '{en: 1'b0, a: (cn ? 3'(ch[0]) : 3'(ch[k])), busy: 1'b1, sd: 1'b1};
            q.push_back(e);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        obs_t idle_o;
        if (!rst_n) begin
            q.delete();
            m <= '0;
        end else begin
            idle_o = '{en: 1'b0, a: m.a, busy: 1'b0, sd: 1'b0};
            if (m.busy) begin
                if (stop) begin
                    q.delete();
                    m <= idle_o;
                end else if (q.size() > 0) begin
                    m <= q.pop_front();
                end else if (m_cont) begin
                    gen_sweep(m_mask, m_dwell, m_cont);
                    m <= q.pop_front();
                end else begin
                    m <= idle_o;
                end
            end else if (start && !stop && mask != 0) begin
                m_mask  <= mask;
                m_dwell <= dwell;
                m_cont  <= cont;
                gen_sweep(mask, dwell, cont);
                m <= q.pop_front();
            end else begin
                m <= idle_o;
            end
        end
    end

    always @(negedge clk) begin
        checks++;
        if ({en, a, busy, sweep_done} !== m) begin
            errors++;
            $display("FAIL model t=%0t got en=%b a=%0d busy=%b sd=%b expected en=%b a=%0d busy=%b sd=%b",
                     $time, en, a, busy, sweep_done, m.en, m.a, m.busy, m.sd);
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    int exp_en[10]   = '{1, 1, 0, 1, 1, 0, 1, 1, 0, 0};
    int exp_a[10]    = '{0, 0, 2, 2, 2, 7, 7, 7, 7, 7};
    int exp_busy[10] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    int exp_sd[10]   = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};

    initial begin
        int sd_cnt;
        int en_cnt;

        // Reset state
        cyc(2);
        chk("rst_en", int'(en), 0);
        chk("rst_a", int'(a), 0);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        cyc(3);
        chk("post_rst_idle", int'(busy), 0);

        // Single sweep 1000_0101, dwell 2
        mask = 8'h85; dwell = 8'd2; cont = 1'b0; start = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            start = 1'b0;
            chk($sformatf("single_en[%0d]", k), int'(en), exp_en[k]);
            chk($sformatf("single_a[%0d]", k), int'(a), exp_a[k]);
            chk($sformatf("single_busy[%0d]", k), int'(busy), exp_busy[k]);
            chk($sformatf("single_sd[%0d]", k), int'(sweep_done), exp_sd[k]);
        end

        // Continuous, single channel 7, dwell 0 treated as 1
        mask = 8'h80; dwell = 8'd0; cont = 1'b1; start = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            start = 1'b0;
            chk("cont_en", int'(en), (k % 2 == 0) ? 1 : 0);
            chk("cont_sd", int'(sweep_done), (k % 2 == 0) ? 0 : 1);
            chk("cont_a", int'(a), 7);
            chk("cont_busy", int'(busy), 1);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("cont_stop_busy", int'(busy), 0);
        cyc(2);

        // Stop at 2nd cycle of channel 3 (cycle 17 after start)
        mask = 8'hFF; dwell = 8'd4; cont = 1'b0; start = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("stop_pre_en", int'(en), 1);
        chk("stop_pre_a", int'(a), 3);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_en", int'(en), 0);
        chk("stop_busy", int'(busy), 0);
        chk("stop_a", int'(a), 3);
        chk("stop_sd", int'(sweep_done), 0);
        cyc(3);

        // Degenerate starts
        mask = 8'h00; start = 1'b1;
        cyc(2);
        chk("mask0_busy", int'(busy), 0);
        chk("mask0_en", int'(en), 0);
        mask = 8'hFF; stop = 1'b1;
        cyc(2);
        start = 1'b0; stop = 1'b0;
        chk("startstop_busy", int'(busy), 0);
        chk("startstop_a", int'(a), 3);

        // Shadowing: changes and restarts while busy are ignored
        mask = 8'h03; dwell = 8'd3; cont = 1'b0; start = 1'b1;
        sd_cnt = 0; en_cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 1) begin mask = 8'hF0; dwell = 8'd1; cont = 1'b1; end
            if (k == 3) start = 1'b1;
            if (sweep_done) sd_cnt++;
            if (en) en_cnt++;
        end
        start = 1'b0;
        chk("shadow_sd_pulses", sd_cnt, 1);
        chk("shadow_en_cycles", en_cnt, 6);
        chk("shadow_end_a", int'(a), 1);

        // Maximum dwell does not wrap
        mask = 8'h01; dwell = 8'd255; cont = 1'b0; start = 1'b1;
        en_cnt = 0;
        for (int k = 0; k < 258; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (en) en_cnt++;
        end
        chk("maxdwell_en_cycles", en_cnt, 255);
        chk("maxdwell_idle", int'(busy), 0);

        // Async reset in the middle of DWELL on channel 5
        mask = 8'h20; dwell = 8'd5; cont = 1'b1; start = 1'b1;
        cyc(3);
        start = 1'b0;
        chk("arst_pre_en", int'(en), 1);
        chk("arst_pre_a", int'(a), 5);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_en", int'(en), 0);
        chk("arst_a", int'(a), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_sd", int'(sweep_done), 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(4);
        chk("arst_stays_idle", int'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dec_scan_ctrl.md
Name: dec_scan_ctrl

Overview:
- Sequencer that sits directly upstream of the 3-to-8 decoder and drives its enable (en) and select (a[2:0]) inputs.
- Steps through the channels set in an 8-bit mask in ascending order.
- Holds each channel for a programmable dwell time and inserts a one-cycle break-before-make gap between channels.
- Runs either a single sweep or continuously, under start/stop control.

Parameters:
- DWELL_W, 8, width of the dwell-count input; maximum dwell is 2^DWELL_W-1 cycles.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  level-sampled; begins a sweep when the block is in IDLE.
- stop  input  1  level-sampled; aborts the active sweep.
- cont  input  1  captured at start; 1 = continuous sweeps, 0 = single sweep.
- mask  input  8  channel enable mask, captured at start; bit i enables channel i.
- dwell  input  DWELL_W  cycles en is held high per channel, captured at start; 0 is treated as 1.
- en  output  1  decoder enable.
- a  output  3  decoder select.
- busy  output  1  high while a sweep is active.
- sweep_done  output  1  one-cycle pulse marking completion of each full sweep.

Behaviour:
- Interface: one clock (clk). Reset is asynchronous and active-low (rst_n).
- While rst_n = 0: state=IDLE, en=0, a=0, busy=0, sweep_done=0, dwell counter=0, shadow registers=0. Outputs clear immediately, without waiting for a clock edge.
- All outputs are registered.
- States: IDLE, DWELL, GAP.
- IDLE:
  - start=1, stop=0, mask!=0: capture mask, dwell and cont into shadow registers; load a = index of the lowest set bit of mask; set en=1, busy=1; go to DWELL. en is visible the cycle after the start edge (latency 1).
  - start=1 with mask==0: ignored; stay in IDLE with no output change.
  - start=1 and stop=1 together: stop wins; stay in IDLE.
- DWELL:
  - en=1 for exactly max(dwell_shadow,1) consecutive cycles; then go to GAP.
  - a is stable throughout DWELL.
- GAP (exactly one cycle, en=0):
  - a advances to the next set bit of the shadow mask strictly above the current a.
  - If there is no higher set bit, the sweep is complete: sweep_done=1 for this cycle.
    - cont=1: a = lowest set bit; return to DWELL.
    - cont=0: a is left unchanged; go to IDLE. busy falls in the cycle after GAP.
  - Otherwise, return to DWELL.
- a changes only while en=0 (the start edge or a GAP cycle), so the decoder never sees a select change while enabled.
- stop=1 sampled in DWELL or GAP: en=0, busy=0 and state=IDLE the next cycle; a holds its value; no sweep_done pulse. A stop in the same cycle as a wrap suppresses that cycle's sweep_done.
- Changes on mask, dwell or cont while busy have no effect until the next start.
- start while busy is ignored.
- Single-bit mask with cont=1 yields en pattern: dwell highs, one low, repeating; sweep_done is pulsed on every GAP.
- Dwell counter has width DWELL_W and must not wrap for dwell = 2^DWELL_W-1.

Decomposition:
- Shared package dec_pkg holds:
  - NUM_CH=8 and SEL_W=3 constants;
  - state enum scan_state_t {IDLE, DWELL, GAP}.
- One combinational sub-module, ch_find_next, is natural:
  - inputs: mask[7:0], cur[2:0], from_start;
  - outputs: nxt[2:0], wrap.
  - It finds the next set bit above cur (or the lowest set bit when from_start=1), and flags wrap when no higher bit exists.
- The FSM and counters stay in dec_scan_ctrl.

Test Plan:
- Async reset: assert rst_n=0 mid-DWELL with en=1, a=5 -> en=0, a=0, busy=0, sweep_done=0 before the next clk edge; after release, the block stays IDLE until start.
- Single sweep, mask=8'b1000_0101, dwell=2, cont=0, start one cycle -> en sequence 1,1,0,1,1,0,1,1,0 with a=0,0,x,2,2,x,7,7,7; sweep_done=1 only on the final gap cycle; busy=0 on the following cycle.
- Continuous, mask=8'h80, dwell=0, cont=1 -> a=7 constant; en toggles 1,0,1,0,…; sweep_done=1 on every en=0 cycle; busy stays 1.
- Stop mid-dwell: mask=8'hFF, dwell=4, assert stop at the 2nd cycle of channel 3 -> en=0, busy=0 the next cycle, a stays 3, no sweep_done.
- Degenerate starts: start with mask=0 -> no output activity; start=1 and stop=1 together in IDLE -> remains IDLE.
- Shadowing: start with mask=8'h03, dwell=3, then change mask to 8'hF0, change dwell to 1, and pulse start while busy -> sweep still visits channels 0 and 1 with 3-cycle dwells and completes exactly once.
